// File: rtl/brick_pkg.sv
// Shared brick type codes, scheduler state encodings and default grid geometry
// for the brick field scheduler and its grid counter.
package brick_pkg;

    typedef logic [2:0] brick_t;

    localparam brick_t NOBRICK = 3'd0;
    localparam brick_t RED     = 3'd1;
    localparam brick_t BROWN   = 3'd2;
    localparam brick_t SRED    = 3'd3;
    localparam brick_t SBROWN  = 3'd4;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_WAIT_MAP = 3'd2;
    localparam logic [2:0] S_LATCH    = 3'd3;
    localparam logic [2:0] S_CLR      = 3'd4;
    localparam logic [2:0] S_DRAW     = 3'd5;
    localparam logic [2:0] S_NEXT     = 3'd6;
    localparam logic [2:0] S_FIN      = 3'd7;

    localparam int unsigned DEF_COLS     = 8;
    localparam int unsigned DEF_ROWS     = 6;
    localparam int unsigned DEF_BRICK_W  = 12;
    localparam int unsigned DEF_BRICK_H  = 6;
    localparam int unsigned DEF_X_ORIGIN = 8;
    localparam int unsigned DEF_Y_ORIGIN = 16;

    // Counter width that never collapses to zero bits for tiny grids.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/brick_field_scheduler_if.sv
// Control, level-map and drawer signals of the brick field scheduler.
interface brick_field_scheduler_if #(
    parameter int unsigned AW = 6
);
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [AW-1:0] map_addr;
    logic [2:0]    map_data;
    logic          draw_reset;
    logic          draw_en;
    logic [2:0]    draw_sel;
    logic          draw_end;
    logic [7:0]    brick_x;
    logic [7:0]    brick_y;
    logic          plot;

    modport slave (
        input  start, abort, map_data, draw_end,
        output busy, done, map_addr, draw_reset, draw_en, draw_sel,
               brick_x, brick_y, plot
    );

    modport master (
        output start, abort, map_data, draw_end,
        input  busy, done, map_addr, draw_reset, draw_en, draw_sel,
               brick_x, brick_y, plot
    );
endinterface

// File: rtl/brick_grid_counter.sv
// Row-major cell walker: column/row counters, level-map address and the
// incrementally tracked screen origin of the current cell.
module brick_grid_counter
    import brick_pkg::*;
#(
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned BRICK_W  = DEF_BRICK_W,
    parameter int unsigned BRICK_H  = DEF_BRICK_H,
    parameter int unsigned X_ORIGIN = DEF_X_ORIGIN,
    parameter int unsigned Y_ORIGIN = DEF_Y_ORIGIN,
    parameter int unsigned AW       = $clog2(COLS*ROWS)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clr,
    input  logic          adv,
    output logic          last_c,
    output logic [AW-1:0] map_addr,
    output logic [7:0]    brick_x,
    output logic [7:0]    brick_y
);
    localparam int unsigned CW = clog2_min1(COLS);
    localparam int unsigned RW = clog2_min1(ROWS);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    x_q, x_d;
    logic [7:0]    y_q, y_d;

    assign last_c   = (col_q == CW'(COLS-1)) && (row_q == RW'(ROWS-1));
    assign map_addr = addr_q;
    assign brick_x  = x_q;
    assign brick_y  = y_q;

    // Advancing past the last cell rewinds to the origin for the next field.
    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        x_d    = x_q;
        y_d    = y_q;
        if (clr || (adv && last_c)) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
            x_d    = 8'(X_ORIGIN);
            y_d    = 8'(Y_ORIGIN);
        end else if (adv) begin
            addr_d = addr_q + AW'(1);
            if (col_q == CW'(COLS-1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
                x_d   = 8'(X_ORIGIN);
                y_d   = y_q + 8'(BRICK_H);
            end else begin
                col_d = col_q + CW'(1);
                x_d   = x_q + 8'(BRICK_W);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
            x_q    <= 8'(X_ORIGIN);
            y_q    <= 8'(Y_ORIGIN);
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end

endmodule

// File: rtl/brick_field_scheduler.sv
// Walks the level's brick grid and runs the brick drawer once per cell.
// Build option SKIP_EMPTY_EN: cells holding NOBRICK are skipped instead of drawn.
module brick_field_scheduler
    import brick_pkg::*;
#(
    parameter int unsigned COLS     = DEF_COLS,
    parameter int unsigned ROWS     = DEF_ROWS,
    parameter int unsigned BRICK_W  = DEF_BRICK_W,
    parameter int unsigned BRICK_H  = DEF_BRICK_H,
    parameter int unsigned X_ORIGIN = DEF_X_ORIGIN,
    parameter int unsigned Y_ORIGIN = DEF_Y_ORIGIN,
    parameter int unsigned AW       = $clog2(COLS*ROWS)
) (
    input logic                     clk,
    input logic                     resetn,
    brick_field_scheduler_if.slave  bus
);
    logic [2:0] state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       draw_reset_q, draw_reset_d;
    logic       draw_en_q, draw_en_d;
    logic       plot_q, plot_d;
    brick_t     draw_sel_q, draw_sel_d;
    logic       adv, clr, last_c;

    brick_grid_counter #(
        .COLS(COLS), .ROWS(ROWS), .BRICK_W(BRICK_W), .BRICK_H(BRICK_H),
        .X_ORIGIN(X_ORIGIN), .Y_ORIGIN(Y_ORIGIN), .AW(AW)
    ) u_grid (
        .clk      (clk),
        .resetn   (resetn),
        .clr      (clr),
        .adv      (adv),
        .last_c   (last_c),
        .map_addr (bus.map_addr),
        .brick_x  (bus.brick_x),
        .brick_y  (bus.brick_y)
    );

    // Next state; abort overrides everything, including a same-cycle start.
    always_comb begin
        state_d = state_q;
        adv     = 1'b0;
        case (state_q)
            S_IDLE:     if (bus.start) state_d = S_FETCH;
            S_FETCH:    state_d = S_WAIT_MAP;
            S_WAIT_MAP: state_d = S_LATCH;
`ifdef SKIP_EMPTY_EN
            S_LATCH:    state_d = (bus.map_data == NOBRICK) ? S_NEXT : S_CLR;
`else
            S_LATCH:    state_d = S_CLR;
`endif
            S_CLR:      state_d = S_DRAW;
            S_DRAW:     if (bus.draw_end) state_d = S_NEXT;
            S_NEXT: begin
                adv     = 1'b1;
                state_d = last_c ? S_FIN : S_FETCH;
            end
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (bus.abort) begin
            state_d = S_IDLE;
            adv     = 1'b0;
        end
        clr = bus.abort;

        busy_d       = (state_d != S_IDLE);
        done_d       = (state_d == S_FIN);
        draw_reset_d = (state_d == S_CLR);
        draw_en_d    = (state_d == S_DRAW);
        plot_d       = (state_q == S_DRAW) && !bus.draw_end && !bus.abort;
        draw_sel_d   = (state_q == S_LATCH) ? bus.map_data : draw_sel_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            draw_reset_q <= 1'b0;
            draw_en_q    <= 1'b0;
            plot_q       <= 1'b0;
            draw_sel_q   <= NOBRICK;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            draw_reset_q <= draw_reset_d;
            draw_en_q    <= draw_en_d;
            plot_q       <= plot_d;
            draw_sel_q   <= draw_sel_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.draw_reset = draw_reset_q;
    assign bus.draw_en    = draw_en_q;
    assign bus.plot       = plot_q;
    assign bus.draw_sel   = draw_sel_q;

endmodule

// File: tb/tb_brick_field_scheduler.sv
// Scoreboard bench for brick_field_scheduler with a level-map RAM and a 12x6 drawer model.
module tb_brick_field_scheduler;
    import brick_pkg::*;

    localparam int unsigned AW     = 6;
    localparam int unsigned NCELL  = 48;
    localparam int          CELL_T = 78;

    typedef struct {
        int sel;
        int x;
        int y;
        int addr;
    } cell_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    brick_field_scheduler_if #(.AW(AW)) bus ();

    brick_field_scheduler u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [2:0] mem [NCELL];
    logic [2:0] map_q;
    logic [6:0] dcnt;
    logic       dend;

    always @(posedge clk) map_q <= mem[bus.map_addr];
    assign bus.map_data = map_q;

    // 12x6 drawer: 72 enabled cycles, then a sticky end flag until reset.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dcnt <= '0;
            dend <= 1'b0;
        end else if (bus.draw_reset) begin
            dcnt <= '0;
            dend <= 1'b0;
        end else if (bus.draw_en && !dend) begin
            if (dcnt == 7'd71) dend <= 1'b1;
            else dcnt <= dcnt + 7'd1;
        end
    end
    assign bus.draw_end = dend;

    int    n_checks = 0;
    int    n_errors = 0;
    cell_t exp_cells[$];
    int    exp_done[$];
    int    rst_cnt  = 0;
    int    done_cnt = 0;
    int    busy_cyc = 0;
    int    plot_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic void push_cell(input int a);
        cell_t c;
        c.sel  = int'(mem[a]);
        c.x    = 8 + (a % 8) * 12;
        c.y    = 16 + (a / 8) * 6;
        c.addr = a;
        exp_cells.push_back(c);
    endfunction

    // Monitor: pops expected cells on draw_reset and expected latency on done.
    initial begin
        cell_t c;
        logic  prev_en = 1'b0;
        logic  prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                plot_cnt  = 0;
                prev_en   = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.plot) plot_cnt++;
                if (bus.draw_reset) begin
                    rst_cnt++;
                    plot_cnt = 0;
                    if (exp_cells.size() == 0) begin
                        chk("unexpected_cell_addr", int'(bus.map_addr), -1);
                    end else begin
                        c = exp_cells.pop_front();
                        chk("cell_addr", int'(bus.map_addr), c.addr);
                        chk("cell_sel", int'(bus.draw_sel), c.sel);
                        chk("cell_x", int'(bus.brick_x), c.x);
                        chk("cell_y", int'(bus.brick_y), c.y);
                    end
                end
                if (prev_en && !bus.draw_en && dend) chk("plot_per_cell", plot_cnt, 72);
                if (prev_done) chk("busy_drops_with_done", int'(bus.busy), 0);
                if (bus.busy && !bus.done) busy_cyc++;
                if (bus.done) begin
                    done_cnt++;
                    chk("busy_during_done", int'(bus.busy), 1);
                    if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                    else chk("done_latency", busy_cyc, exp_done.pop_front());
                end
                prev_en   = bus.draw_en;
                prev_done = bus.done;
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_draw_en"}, int'(bus.draw_en), 0);
        chk({tag, "_draw_reset"}, int'(bus.draw_reset), 0);
        chk({tag, "_plot"}, int'(bus.plot), 0);
        chk({tag, "_draw_sel"}, int'(bus.draw_sel), 0);
        chk({tag, "_map_addr"}, int'(bus.map_addr), 0);
        chk({tag, "_brick_x"}, int'(bus.brick_x), 8);
        chk({tag, "_brick_y"}, int'(bus.brick_y), 16);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        busy_cyc  = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) return;
        end
        chk({name, "_timeout"}, done_cnt - d0, 1);
    endtask

    task automatic wait_resets(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rst_cnt >= n) return;
            tick();
        end
        chk({name, "_timeout"}, rst_cnt, n);
    endtask

    task automatic fill_mem(input logic [2:0] v);
        for (int i = 0; i < int'(NCELL); i++) mem[i] = v;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        fill_mem(RED);
        repeat (3) tick();
        check_reset_vals("in_reset");
        resetn = 1'b1;
        tick();
        check_reset_vals("after_reset");

        // Full field, cells 0/1 RED/BROWN, plus an ignored start mid-field.
        mem[1] = BROWN;
        for (int a = 0; a < int'(NCELL); a++) push_cell(a);
        exp_done.push_back(int'(NCELL) * CELL_T);
        rst_cnt = 0;
        pulse_start();
        repeat (1000) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("full_field", 5000);
        repeat (10) tick();
        chk("full_done_count", done_cnt, 1);
        chk("full_draw_resets", rst_cnt, int'(NCELL));
        chk("full_cells_left", exp_cells.size(), 0);
        chk("full_busy_after", int'(bus.busy), 0);

        // Mostly empty map: only address 5 holds SRED.
        fill_mem(NOBRICK);
        mem[5] = SRED;
        rst_cnt = 0;
`ifdef SKIP_EMPTY_EN
        push_cell(5);
        exp_done.push_back(47 * 4 + CELL_T);
`else
        for (int a = 0; a < int'(NCELL); a++) push_cell(a);
        exp_done.push_back(int'(NCELL) * CELL_T);
`endif
        pulse_start();
        wait_done("sparse_field", 5000);
        repeat (10) tick();
`ifdef SKIP_EMPTY_EN
        chk("sparse_draw_resets", rst_cnt, 1);
`else
        chk("sparse_draw_resets", rst_cnt, int'(NCELL));
`endif
        chk("sparse_cells_left", exp_cells.size(), 0);
        chk("sparse_done_count", done_cnt, 2);

        // Abort during the 30th DRAW cycle of the third cell.
        fill_mem(RED);
        for (int a = 0; a < 3; a++) push_cell(a);
        rst_cnt = 0;
        pulse_start();
        wait_resets("abort_third_cell", 3, 1000);
        for (int i = 0; i < 10 && !bus.draw_en; i++) tick();
        repeat (29) tick();
        chk("abort_draw_en_before", int'(bus.draw_en), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_draw_en", int'(bus.draw_en), 0);
        chk("abort_plot", int'(bus.plot), 0);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_map_addr", int'(bus.map_addr), 0);
        chk("abort_brick_x", int'(bus.brick_x), 8);
        repeat (40) tick();
        chk("abort_no_done", done_cnt, 2);
        chk("abort_cells_left", exp_cells.size(), 0);

        // start and abort together in IDLE: abort wins.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        chk("start_abort_idle_busy", int'(bus.busy), 0);

        // Restart from address 0, then asynchronous reset mid-DRAW.
        for (int a = 0; a < 2; a++) push_cell(a);
        rst_cnt = 0;
        pulse_start();
        wait_resets("restart", 2, 1000);
        repeat (10) tick();
        chk("pre_reset_draw_en", int'(bus.draw_en), 1);
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check_reset_vals("async_reset");
        tick();
        tick();
        resetn = 1'b1;
        repeat (20) tick();
        chk("reset_no_done", done_cnt, 2);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_cells_left", exp_cells.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
